muldiv_unit: RTL

Parametrised iterative multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It is the multi-cycle companion to the single-cycle combinational ALU and sits beside it in the execute stage. Operands arrive on a valid/ready request channel, and results leave on a valid/ready response channel. The core computes one result bit per cycle and has fast paths for the RISC-V divide corner cases.

---
 rtl/muldiv_unit_pkg.sv | 37 +++
 rtl/muldiv_negate.sv | 12 +
 rtl/muldiv_unit.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 op codes, FSM state encodings and op-class predicates.
package muldiv_unit_pkg;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_rem(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    function automatic logic is_signed_a(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement: passes the value through or negates it.
module muldiv_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] res_o
);

    assign res_o = neg_i ? (~val_i + WIDTH'(1)) : val_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one result bit per cycle on a shared
// 2*WIDTH accumulator, with single-cycle paths for the divide corner cases.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [2:0]           op_q, op_d;
    logic                 neg_q, neg_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;

    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_trial;
    logic [WIDTH-1:0]     div_sub;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   fix_in, fix_out;

    assign a_neg = is_signed_a(op) && a[WIDTH-1];
    assign b_neg = is_signed_b(op) && b[WIDTH-1];

    muldiv_negate #(.WIDTH(WIDTH)) u_neg_a (.val_i(a), .neg_i(a_neg), .res_o(a_mag));
    muldiv_negate #(.WIDTH(WIDTH)) u_neg_b (.val_i(b), .neg_i(b_neg), .res_o(b_mag));

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

    // Divide: acc = {partial remainder, remaining dividend / quotient bits}, shifted left.
    assign div_trial = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_ge    = div_trial >= {1'b0, opnd_q};
    assign div_sub   = div_trial[WIDTH-1:0] - opnd_q;

    always_comb begin
        fix_in = acc_q;
        if (is_rem(op_q)) begin
            fix_in = {{WIDTH{1'b0}}, acc_q[2*WIDTH-1:WIDTH]};
        end else if (is_div(op_q)) begin
            fix_in = {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
        end
    end

    muldiv_negate #(.WIDTH(2*WIDTH)) u_neg_fix (.val_i(fix_in), .neg_i(neg_q), .res_o(fix_out));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        opnd_d      = opnd_q;
        op_d        = op_q;
        neg_d       = neg_q;
        result_d    = result_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    op_d       = op;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    if (is_div(op) && (b == '0)) begin
                        result_d    = op[1] ? a : '1;
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end else if (((op == MD_DIV) || (op == MD_REM)) && (a == MOST_NEG) && (b == '1)) begin
                        result_d    = op[1] ? '0 : a;
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end else if (is_div(op)) begin
                        acc_d   = {{WIDTH{1'b0}}, a_mag};
                        opnd_d  = b_mag;
                        neg_d   = op[1] ? a_neg : (a_neg ^ b_neg);
                        state_d = ST_CALC;
                    end else begin
                        acc_d   = {{WIDTH{1'b0}}, b_mag};
                        opnd_d  = a_mag;
                        neg_d   = a_neg ^ b_neg;
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (is_div(op_q)) begin
                    acc_d = {(div_ge ? div_sub : div_trial[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                if (cnt_q == LAST_ITER) begin
                    cnt_d   = '0;
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FIX: begin
                result_d    = ((op_q == MD_MUL) || is_div(op_q)) ? fix_out[WIDTH-1:0]
                                                                 : fix_out[2*WIDTH-1:WIDTH];
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Flush outranks the response handshake and drops any pending result.
        if (flush && (state_q != ST_IDLE)) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            opnd_q      <= '0;
            op_q        <= MD_MUL;
            neg_q       <= 1'b0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            opnd_q      <= opnd_d;
            op_q        <= op_d;
            neg_q       <= neg_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule
